// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: mode-selectable LED pattern generator.
// Ports: clk_48mhz, resetn (async low), mode[2:0] in; led_out, step out.
module led_pattern_ctrl #(
  parameter int NUM_LEDS   = 4,
  parameter int STEP_DIV   = 2097152,
  parameter int DUTY_DIV   = 8192,
  parameter int PWM_BITS   = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk_48mhz,
  input  logic                resetn,
  input  logic [2:0]          mode,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                step
);

  localparam int STEP_W = $clog2(STEP_DIV);
  localparam int DCNT_W = $clog2(DUTY_DIV);
  localparam int POS_W  =
    (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [STEP_W-1:0] STEP_LAST =
    STEP_W'(STEP_DIV - 1);
  localparam logic [DCNT_W-1:0] DUTY_LAST =
    DCNT_W'(DUTY_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST =
    POS_W'(NUM_LEDS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX =
    {PWM_BITS{1'b1}};
  localparam logic [NUM_LEDS-1:0] LED_ONE =
    NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] LED_DARK =
    (ACTIVE_LOW != 0) ? {NUM_LEDS{1'b1}}
                      : {NUM_LEDS{1'b0}};

  localparam logic [2:0] M_ON      = 3'd1;
  localparam logic [2:0] M_BLINK   = 3'd2;
  localparam logic [2:0] M_CYLON   = 3'd3;
  localparam logic [2:0] M_CHASE   = 3'd4;
  localparam logic [2:0] M_BREATHE = 3'd5;

  logic [2:0]          mode_q, mode_d;
  logic [STEP_W-1:0]   scnt_q, scnt_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                dir_dn_q, dir_dn_d;
  logic                phase_q, phase_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                duty_dn_q, duty_dn_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [NUM_LEDS-1:0] lit;

  logic restart;
  logic step_hit;
  logic duty_hit;
  logic is_on, is_blink, is_cylon;
  logic is_chase, is_breathe;

  assign restart  = (mode != mode_q);
  assign step_hit = (scnt_q == STEP_LAST);
  assign duty_hit = (dcnt_q == DUTY_LAST);

  assign is_on      = (mode_q == M_ON);
  assign is_blink   = (mode_q == M_BLINK);
  assign is_cylon   = (mode_q == M_CYLON);
  assign is_chase   = (mode_q == M_CHASE);
  assign is_breathe = (mode_q == M_BREATHE);

  always_comb begin
    mode_d    = mode;
    scnt_d    = step_hit ? '0 : scnt_q + 1'b1;
    dcnt_d    = duty_hit ? '0 : dcnt_q + 1'b1;
    pwm_d     = pwm_q + 1'b1;
    pos_d     = pos_q;
    dir_dn_d  = dir_dn_q;
    phase_d   = phase_q;
    duty_d    = duty_q;
    duty_dn_d = duty_dn_q;

    // Triangle duty: turn around at the extremes
    // without dwelling on them.
    if (duty_hit) begin
      if (!duty_dn_q) begin
        if (duty_q == DUTY_MAX) begin
          duty_dn_d = 1'b1;
          duty_d    = duty_q - 1'b1;
        end else begin
          duty_d = duty_q + 1'b1;
        end
      end else begin
        if (duty_q == '0) begin
          duty_dn_d = 1'b0;
          duty_d    = duty_q + 1'b1;
        end else begin
          duty_d = duty_q - 1'b1;
        end
      end
    end

    if (step_hit) begin
      unique case (1'b1)
        is_blink: phase_d = ~phase_q;
        is_cylon: begin
          if (NUM_LEDS > 1) begin
            if (!dir_dn_q) begin
              if (pos_q == POS_LAST) begin
                dir_dn_d = 1'b1;
                pos_d    = pos_q - 1'b1;
              end else begin
                pos_d = pos_q + 1'b1;
              end
            end else begin
              if (pos_q == '0) begin
                dir_dn_d = 1'b0;
                pos_d    = pos_q + 1'b1;
              end else begin
                pos_d = pos_q - 1'b1;
              end
            end
          end
        end
        is_chase: begin
          if (NUM_LEDS > 1) begin
            pos_d = (pos_q == POS_LAST)
                  ? '0 : pos_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    // A mode change wins over any step or duty
    // advance landing on the same edge.
    if (restart) begin
      scnt_d    = '0;
      dcnt_d    = '0;
      pwm_d     = '0;
      pos_d     = '0;
      dir_dn_d  = 1'b0;
      phase_d   = 1'b0;
      duty_d    = '0;
      duty_dn_d = 1'b0;
    end
  end

  // OFF and the reserved codes fall to default.
  always_comb begin
    lit = '0;
    unique case (1'b1)
      is_on:      lit = {NUM_LEDS{1'b1}};
      is_blink:   lit = phase_q ? LED_ONE : '0;
      is_cylon,
      is_chase:   lit = LED_ONE << pos_q;
      is_breathe: lit = (pwm_q < duty_q)
                      ? {NUM_LEDS{1'b1}} : '0;
      default:    lit = '0;
    endcase
    led_d = (ACTIVE_LOW != 0) ? ~lit : lit;
  end

  always_ff @(posedge clk_48mhz or negedge resetn) begin
    if (!resetn) begin
      mode_q    <= '0;
      scnt_q    <= '0;
      dcnt_q    <= '0;
      pwm_q     <= '0;
      pos_q     <= '0;
      dir_dn_q  <= 1'b0;
      phase_q   <= 1'b0;
      duty_q    <= '0;
      duty_dn_q <= 1'b0;
      led_q     <= LED_DARK;
    end else begin
      mode_q    <= mode_d;
      scnt_q    <= scnt_d;
      dcnt_q    <= dcnt_d;
      pwm_q     <= pwm_d;
      pos_q     <= pos_d;
      dir_dn_q  <= dir_dn_d;
      phase_q   <= phase_d;
      duty_q    <= duty_d;
      duty_dn_q <= duty_dn_d;
      led_q     <= led_d;
    end
  end

  assign led_out = led_q;
  assign step    = step_hit;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: vector table, corner sequences
// and randomized run against an age-based pattern model.
module tb_led_pattern_ctrl;

  logic       clk;
  logic       resetn;
  logic [2:0] mode;
  logic [3:0] led_out;
  logic       step;
  logic [2:0] mode2;
  logic [3:0] led2;
  logic       step2;

  led_pattern_ctrl #(
    .NUM_LEDS(4), .STEP_DIV(4), .DUTY_DIV(2),
    .PWM_BITS(3), .ACTIVE_LOW(1)
  ) dut (
    .clk_48mhz(clk), .resetn(resetn), .mode(mode),
    .led_out(led_out), .step(step)
  );

  // Slow duty so one duty value spans one PWM window.
  led_pattern_ctrl #(
    .NUM_LEDS(4), .STEP_DIV(4), .DUTY_DIV(8),
    .PWM_BITS(3), .ACTIVE_LOW(1)
  ) dut2 (
    .clk_48mhz(clk), .resetn(resetn), .mode(mode2),
    .led_out(led2), .step(step2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: pattern is a function of mode and the
  // number of cycles since the last restart.
  int         m_mode = 0;
  int         m_k    = 0;
  logic [3:0] m_led  = 4'hF;
  logic       m_step = 1'b0;

  function automatic int tri_f(int n, int m);
    int r;
    if (m == 0) return 0;
    r = n % (2 * m);
    return (r <= m) ? r : 2 * m - r;
  endfunction

  function automatic logic [3:0] pat(int md, int k);
    logic [3:0] one;
    logic [3:0] mask;
    one  = 4'b0001;
    mask = 4'h0;
    case (md)
      1: mask = 4'hF;
      2: mask = (((k / 4) % 2) == 1) ? one : 4'h0;
      3: mask = one << tri_f(k / 4, 3);
      4: mask = one << ((k / 4) % 4);
      5: mask = ((k % 8) < tri_f(k / 2, 7))
              ? 4'hF : 4'h0;
      default: mask = 4'h0;
    endcase
    return ~mask;
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (!resetn) begin
      m_mode = 0;
      m_k    = 0;
      m_led  = 4'hF;
    end else begin
      m_led = pat(m_mode, m_k);
      if (int'(mode) != m_mode) begin
        m_mode = int'(mode);
        m_k    = 0;
      end else begin
        m_k++;
      end
    end
    m_step = ((m_k % 4) == 3);
    @(negedge clk);
  endtask

  task automatic chk(input string nm,
                     input logic [3:0] got,
                     input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b @%0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic chk_i(input string nm,
                       input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, got, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic [2:0] md;
    logic [3:0] led;
    logic       stp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic [2:0] m,
                              logic [3:0] l, logic s);
    vec_t v;
    v.rst_n = r;
    v.md    = m;
    v.led   = l;
    v.stp   = s;
    tbl.push_back(v);
  endfunction

  int cyl_seq[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
  int duty_seq[15] =
    '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};

  initial begin
    logic [3:0] one;
    int         lit;
    int         hold;
    one    = 4'b0001;
    resetn = 1'b1;
    mode   = 3'd1;
    mode2  = 3'd0;
    #2 resetn = 1'b0;

    // Reset, then ON.
    add(0, 1, 4'hF, 0);
    add(1, 1, 4'hF, 0);
    add(1, 1, 4'h0, 0);
    add(1, 1, 4'h0, 0);
    add(1, 1, 4'h0, 1);
    add(1, 1, 4'h0, 0);
    // CYLON bounce, each index held 4 cycles.
    add(1, 3, 4'h0, 0);
    for (int j = 1; j <= 32; j++)
      add(1, 3, ~(one << cyl_seq[(j - 1) / 4]),
          (j % 4) == 3);
    // CHASE, then back to CYLON at pos 2.
    add(1, 4, 4'b1011, 0);
    for (int j = 1; j <= 26; j++)
      add(1, 4, ~(one << (((j - 1) / 4) % 4)),
          (j % 4) == 3);
    add(1, 3, 4'b1011, 0);
    add(1, 3, 4'b1110, 0);
    add(1, 3, 4'b1110, 0);
    add(1, 3, 4'b1110, 1);
    // Mode change on a step cycle: restart wins.
    add(1, 4, 4'b1110, 0);
    add(1, 4, 4'b1110, 0);
    add(1, 4, 4'b1110, 0);
    add(1, 4, 4'b1110, 1);
    add(1, 4, 4'b1110, 0);
    add(1, 4, 4'b1101, 0);
    // Reserved and OFF modes stay dark.
    add(1, 6, 4'b1101, 0);
    add(1, 6, 4'hF, 0);
    add(1, 6, 4'hF, 0);
    add(1, 6, 4'hF, 1);
    add(1, 7, 4'hF, 0);
    add(1, 7, 4'hF, 0);
    add(1, 0, 4'hF, 0);
    add(1, 0, 4'hF, 0);

    foreach (tbl[i]) begin
      resetn = tbl[i].rst_n;
      mode   = tbl[i].md;
      cyc();
      chk($sformatf("tbl%0d_led", i), led_out, tbl[i].led);
      chk($sformatf("tbl%0d_step", i),
          {3'b0, step}, {3'b0, tbl[i].stp});
    end

    // BLINK, then a one-cycle reset with phase=1.
    mode = 3'd2;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("blink_dark", led_out, 4'hF);
    end
    cyc();
    chk("blink_lit", led_out, 4'b1110);
    cyc();
    resetn = 1'b0;
    #1;
    chk("rst_async_led", led_out, 4'hF);
    chk("rst_async_step", {3'b0, step}, 4'h0);
    cyc();
    chk("rst_hold_led", led_out, 4'hF);
    resetn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("rst_resume_dark", led_out, 4'hF);
    end
    cyc();
    chk("rst_relight", led_out, 4'b1110);

    // BREATHE windows on the slow-duty instance.
    mode2 = 3'd5;
    cyc();
    for (int w = 0; w < 15; w++) begin
      lit = 0;
      for (int c = 0; c < 8; c++) begin
        cyc();
        if (led2 == 4'h0) lit++;
        else if (led2 != 4'hF)
          chk("breathe_level", led2, 4'hF);
      end
      chk_i($sformatf("breathe_w%0d_lit", w),
            lit, duty_seq[w]);
      if (w == 7)
        chk_i("breathe_max_unlit", 8 - lit, 1);
    end
    mode2 = 3'd0;

    // Randomized modes and resets against the model.
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 15) == 0) begin
        resetn = 1'b0;
        cyc();
        chk("rnd_rst_led", led_out, m_led);
        resetn = 1'b1;
      end
      mode = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 14);
      for (int c = 0; c < hold; c++) begin
        cyc();
        chk("rnd_led", led_out, m_led);
        chk("rnd_step", {3'b0, step}, {3'b0, m_step});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
